i2c_reg_target: RTL and testbench

//  Clocked I2C responder (target) with an internal byte-wide register file; the far end of i2c_master on the shared SDA/SCL bus.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_reg_target.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
//   tgt_state_t : target FSM state encoding
//   I2C_ACK/NACK: bus level of the 9th (acknowledge) bit
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK,
        WR_PTR,
        WR_DATA,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives single-cycle event pulses.
// Ports:
//   clk, reset        : system clock, asynchronous active-low reset
//   scl_i, sda_i      : raw bus lines
//   scl_o, sda_o      : synchronised line levels
//   scl_rise_o/fall_o : 1-clk pulses on synchronised SCL edges
//   start_det_o       : SDA fell while SCL high
//   stop_det_o        : SDA rose while SCL high
`timescale 1ns/1ps
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Reset to the idle-bus level so no spurious edge is seen after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    always_comb begin
        scl_o       = scl_q[1];
        sda_o       = sda_q[1];
        scl_rise_o  = scl_q[1] & ~scl_q[2];
        scl_fall_o  = ~scl_q[1] & scl_q[2];
        // SCL must be high both before and after the SDA transition.
        start_det_o = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
        stop_det_o  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register file: pointer-plus-data writes and
// auto-incrementing reads, no clock stretching.
// Ports:
//   clk, reset  : system clock, asynchronous active-low reset
//   SDA         : open-drain data line (driven 0 or z only)
//   SCL         : bus clock input
//   host_addr   : local read-back index; host_rdata = regs[host_addr]
//   wr_strobe   : 1-clk pulse per bus register write, with wr_addr/wr_data
//   busy        : high from an address-matched START until STOP
`timescale 1ns/1ps
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned NREGS    = 16,
    localparam int unsigned PW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    inout  wire           SDA,
    input  logic          SCL,
    input  logic [PW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .scl_o      (scl_s),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det)
    );

    tgt_state_t    state_q, state_d, ack_nxt_q, ack_nxt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          oe_q, oe_d, busy_q, busy_d, strobe_q, strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          reg_we;
    logic [7:0]    regs_q [NREGS];

    // NREGS is a power of two, so the natural PW-bit overflow is the wrap.
    assign ptr_inc = ptr_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    ADDR, WR_PTR, WR_DATA: begin
                        if (cnt_q < 4'd8) begin
                            sh_d  = {sh_q[6:0], sda_s};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    RD_BYTE: if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    RD_ACK: begin
                        if (sda_s == I2C_ACK) begin
                            ptr_d = ptr_inc;
                            sh_d  = regs_q[ptr_inc];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
            // Every drive change happens here, one clk after the SCL fall pulse.
            if (scl_fall) begin
                case (state_q)
                    ADDR: begin
                        if (cnt_q == 4'd8) begin
                            if (sh_q[7:1] == DEV_ADDR) begin
                                state_d   = ACK;
                                oe_d      = 1'b1;
                                busy_d    = 1'b1;
                                ack_nxt_d = sh_q[0] ? RD_BYTE : WR_PTR;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                    WR_PTR: begin
                        if (cnt_q == 4'd8) begin
                            ptr_d     = sh_q[PW-1:0];
                            state_d   = ACK;
                            oe_d      = 1'b1;
                            ack_nxt_d = WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (cnt_q == 4'd8) begin
                            reg_we    = 1'b1;
                            strobe_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sh_q;
                            ptr_d     = ptr_inc;
                            state_d   = ACK;
                            oe_d      = 1'b1;
                            ack_nxt_d = WR_DATA;
                        end
                    end
                    ACK: begin
                        state_d = ack_nxt_q;
                        cnt_d   = '0;
                        if (ack_nxt_q == RD_BYTE) begin
                            sh_d = regs_q[ptr_q];
                            oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            oe_d = 1'b0;
                        end
                    end
                    RD_BYTE: begin
                        if (cnt_q == 4'd8) begin
                            state_d = RD_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                            oe_d = ~sh_q[6];
                        end
                    end
                    // Only reached after an ACK; a NACK already left on the rise.
                    RD_ACK: begin
                        state_d = RD_BYTE;
                        cnt_d   = '0;
                        oe_d    = ~sh_q[7];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ack_nxt_q <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[ptr_q] <= sh_q;
        end
    end

    assign SDA        = oe_q ? 1'b0 : 1'bz;
    assign host_rdata = regs_q[host_addr];
    assign wr_strobe  = strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
module tb_i2c_reg_target;

    localparam int Q = 60;  // quarter SCL period: 6 clk

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       SCL = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        SDA;

    pullup (SDA);
    assign SDA = m_sda_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_reg_target #(
        .DEV_ADDR(7'h50),
        .NREGS   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SDA       (SDA),
        .SCL       (SCL),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_str = 0;
    logic [3:0] log_addr [16];
    logic [7:0] log_data [16];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (n_str < 16) begin
                log_addr[n_str] = wr_addr;
                log_data[n_str] = wr_data;
            end
            n_str++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0;
        #(Q);
        SCL = 1'b1;
        #(Q);
        m_sda_oe = 1'b1;
        #(Q);
        SCL = 1'b0;
    endtask

    task automatic bus_stop();
        #(Q);
        m_sda_oe = 1'b1;
        #(Q);
        SCL = 1'b1;
        #(Q);
        m_sda_oe = 1'b0;
        #(Q);
    endtask

    task automatic send_bit(input logic b);
        #(Q);
        m_sda_oe = ~b;
        #(Q);
        SCL = 1'b1;
        #(2 * Q);
        SCL = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        #(Q);
        m_sda_oe = 1'b0;
        #(Q);
        SCL = 1'b1;
        #(Q);
        b = (SDA === 1'b0) ? 1'b0 : 1'b1;
        #(Q);
        SCL = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(mack);
    endtask

    logic       ack;
    logic [7:0] rd;
    int         str0;

    initial begin
        // Reset values
        #23;
        check_eq("rst_sda", SDA, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_strobe", wr_strobe, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_rdata", host_rdata, 0);
        reset = 1'b1;
        #(4 * Q);

        // 1: pointer + two data bytes
        bus_start();
        write_byte(8'hA0, ack); check_eq("t1_ack_addr", ack, 0);
        check_eq("t1_busy", busy, 1);
        write_byte(8'h03, ack); check_eq("t1_ack_ptr", ack, 0);
        write_byte(8'h5A, ack); check_eq("t1_ack_d0", ack, 0);
        write_byte(8'hC3, ack); check_eq("t1_ack_d1", ack, 0);
        bus_stop();
        check_eq("t1_nstrobe", n_str, 2);
        check_eq("t1_s0_addr", log_addr[0], 3);
        check_eq("t1_s0_data", log_data[0], 8'h5A);
        check_eq("t1_s1_addr", log_addr[1], 4);
        check_eq("t1_s1_data", log_data[1], 8'hC3);
        host_addr = 4'd4;
        #1 check_eq("t1_rdata4", host_rdata, 8'hC3);
        check_eq("t1_busy_end", busy, 0);

        // 2: set pointer, repeated start, read two bytes
        bus_start();
        write_byte(8'hA0, ack); check_eq("t2_ack_addr", ack, 0);
        write_byte(8'h03, ack); check_eq("t2_ack_ptr", ack, 0);
        bus_start();
        write_byte(8'hA1, ack); check_eq("t2_ack_raddr", ack, 0);
        read_byte(1'b0, rd); check_eq("t2_rd0", rd, 8'h5A);
        read_byte(1'b1, rd); check_eq("t2_rd1", rd, 8'hC3);
        #(Q) check_eq("t2_sda_rel", SDA, 1);
        bus_stop();
        check_eq("t2_busy_end", busy, 0);

        // 3: foreign address
        str0 = n_str;
        bus_start();
        write_byte(8'hA2, ack); check_eq("t3_nack_addr", ack, 1);
        check_eq("t3_busy", busy, 0);
        write_byte(8'h00, ack); check_eq("t3_nack_data", ack, 1);
        bus_stop();
        check_eq("t3_nstrobe", n_str, str0);

        // 4: pointer wrap on write and read
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check_eq("t4_ack_d1", ack, 0);
        bus_stop();
        host_addr = 4'd15;
        #1 check_eq("t4_reg15", host_rdata, 8'h11);
        host_addr = 4'd0;
        #1 check_eq("t4_reg0", host_rdata, 8'h22);
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        bus_start();
        write_byte(8'hA1, ack);
        read_byte(1'b0, rd); check_eq("t4_rd15", rd, 8'h11);
        read_byte(1'b1, rd); check_eq("t4_rd0", rd, 8'h22);
        bus_stop();

        // 5: STOP in the middle of a data byte
        str0 = n_str;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        check_eq("t5_nstrobe", n_str, str0);
        host_addr = 4'd2;
        #1 check_eq("t5_reg2", host_rdata, 8'h00);
        bus_start();
        write_byte(8'hA0, ack); check_eq("t5_ack_again", ack, 0);
        bus_stop();

        // 6: reset while the target drives a 0 read bit (regs[0]=0x22)
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        bus_start();
        write_byte(8'hA1, ack);
        #(Q) check_eq("t6_drive0", SDA, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_eq("t6_sda_rel", SDA, 1);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_wr_addr", wr_addr, 0);
        check_eq("t6_wr_data", wr_data, 0);
        check_eq("t6_strobe", wr_strobe, 0);
        #(Q);
        SCL = 1'b1;
        #(Q);
        reset = 1'b1;
        #(2 * Q);
        for (int i = 0; i < 16; i++) begin
            host_addr = 4'(i);
            #1 check_eq($sformatf("t6_reg%0d", i), host_rdata, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
